// File: rtl/cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// cpu_trace_buffer : per-cycle CPU execution-record FIFO with halt and overflow tracking
// rev 1.0
// ============================================================================
module cpu_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       cap_en,
  input  logic [31:0]                curPC,
  input  logic [5:0]                 Opcode,
  input  logic [31:0]                Result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [5:0]                 out_opcode,
  output logic [31:0]                out_result,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic                       halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALTED  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] res;
  } rec_t;

  state_t r_state, w_state_nxt;

  rec_t          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  logic w_wr_attempt, w_pop, w_full, w_do_write, w_drop;

  assign w_wr_attempt = cap_en && (r_state != HALTED);
  assign w_pop        = (r_count != '0) && out_ready;
  assign w_full       = (r_count == C_FULL);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
  assign w_do_write   = w_wr_attempt && (!w_full || w_pop);
  assign w_drop       = w_wr_attempt && w_full && !w_pop;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cap_en) w_state_nxt = CAPTURE;
      CAPTURE: if (!cap_en) w_state_nxt = IDLE;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
    if (w_wr_attempt && (Opcode == HALT_OPCODE)) w_state_nxt = HALTED;
  end

  // Storage is intentionally left out of reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (w_do_write) r_mem[r_wr_ptr] <= '{pc: curPC, op: Opcode, res: Result};
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_do_write) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)      r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_write, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign out_valid  = (r_count != '0);
  assign out_pc     = out_valid ? r_mem[r_rd_ptr].pc  : 32'd0;
  assign out_opcode = out_valid ? r_mem[r_rd_ptr].op  : 6'd0;
  assign out_result = out_valid ? r_mem[r_rd_ptr].res : 32'd0;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;
  assign halted     = (r_state == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_buffer.sv
`default_nettype none
// ============================================================================
// tb_cpu_trace_buffer : scoreboard bench for cpu_trace_buffer
// rev 1.0
// ============================================================================
module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam logic [5:0] HALT = 6'h3F;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        cap_en = 1'b0;
  logic [31:0] curPC = '0;
  logic [5:0]  Opcode = '0;
  logic [31:0] Result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [31:0] out_result;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        halted;

  cpu_trace_buffer #(.DEPTH(DEPTH), .HALT_OPCODE(HALT)) dut (
    .CLK(CLK), .Reset(Reset), .cap_en(cap_en), .curPC(curPC), .Opcode(Opcode),
    .Result(Result), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_result(out_result), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [31:0] res;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: occupancy and status after the most recent edge.
  int   m_cnt = 0;
  int   m_drop = 0;
  bit   m_ovf = 0;
  bit   m_halted = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", 96'(count), 96'(m_cnt));
    chk("out_valid", 96'(out_valid), 96'(m_cnt != 0));
    chk("overflow", 96'(overflow), 96'(m_ovf));
    chk("drop_cnt", 96'(drop_cnt), 96'(m_drop));
    chk("halted", 96'(halted), 96'(m_halted));
  endtask

  task automatic cycle(input bit en, input logic [31:0] pc, input logic [5:0] op,
                       input logic [31:0] res, input bit rdy);
    bit w, p;
    @(negedge CLK);
    check_state();
    cap_en = en; curPC = pc; Opcode = op; Result = res; out_ready = rdy;
    w = en && !m_halted;
    p = (m_cnt != 0) && rdy;
    if (w) begin
      if (m_cnt < DEPTH || p) begin
        sb.push_back('{pc: pc, op: op, res: res});
        m_cnt++;
      end else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
      if (op == HALT) m_halted = 1;
    end
    if (p) m_cnt--;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    check_state();
    cap_en = 0; out_ready = 0;
    #3 Reset = 1;
    #1;
    chk("rst_count", 96'(count), 96'd0);
    chk("rst_valid", 96'(out_valid), 96'd0);
    chk("rst_out", {26'd0, out_pc, out_opcode, out_result}, 96'd0);
    chk("rst_status", {78'd0, overflow, drop_cnt, halted}, 96'd0);
    m_cnt = 0; m_drop = 0; m_ovf = 0; m_halted = 0;
    sb.delete();
    @(negedge CLK);
    Reset = 0;
  endtask

  task automatic drain();
    int guard = 0;
    while (m_cnt != 0 && guard < 4 * DEPTH) begin
      cycle(0, '0, '0, '0, 1);
      guard++;
    end
    cycle(0, '0, '0, '0, 0);
    chk("drain_done", 96'(m_cnt), 96'd0);
  endtask

  // Monitor: after inputs settle each cycle, a head that is about to be popped must match the scoreboard.
  initial begin
    rec_t exp;
    forever begin
      @(negedge CLK);
      #1;
      if (!Reset) begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL pop_unexpected: got pc %0h with empty scoreboard at %0t", out_pc, $time);
          end else begin
            exp = sb.pop_front();
            chk("head_record", {26'd0, out_pc, out_opcode, out_result}, {26'd0, exp});
          end
        end else if (!out_valid) begin
          chk("idle_zero", {26'd0, out_pc, out_opcode, out_result}, 96'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    logic [5:0]  op;
    repeat (2) @(negedge CLK);
    Reset = 0;

    // Basic capture
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'(4 * i), 6'h00, 32'(i + 1), 0);
    cycle(0, '0, '0, '0, 0);
    chk("basic_count3", 96'(count), 96'd3);
    drain();

    // Overflow
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 32'(4 * i), 6'h01, 32'(i), 0);
    cycle(0, '0, '0, '0, 0);
    chk("ovf_count", 96'(count), 96'd16);
    chk("ovf_drops", 96'(drop_cnt), 96'd4);
    drain();

    // Full with simultaneous pop
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 32'(4 * i), 6'h02, 32'(i), 0);
    for (int i = 16; i < 21; i++) cycle(1, 32'(4 * i), 6'h02, 32'(i), 1);
    cycle(0, '0, '0, '0, 0);
    chk("fullpop_count", 96'(count), 96'd16);
    chk("fullpop_drops", 96'(drop_cnt), 96'd0);
    drain();

    // Halt
    do_reset();
    cycle(1, 32'h0, 6'h00, 32'd10, 0);
    cycle(1, 32'h4, 6'h00, 32'd11, 0);
    cycle(1, 32'h8, HALT,  32'd12, 0);
    for (int i = 0; i < 4; i++) cycle(1, 32'(12 + 4 * i), 6'h00, 32'(20 + i), 0);
    cycle(0, '0, '0, '0, 0);
    chk("halt_count", 96'(count), 96'd3);
    chk("halt_flag", 96'(halted), 96'd1);
    drain();
    cycle(1, 32'h100, 6'h00, 32'd1, 1);
    cycle(0, '0, '0, '0, 0);
    chk("halt_nocap", 96'(count), 96'd0);

    // Pointer wrap
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1, 32'(4 * i), 6'h03, 32'(~i), 1);
    drain();

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 32'(32'h40 + 4 * i), 6'h04, 32'(i), 0);
    do_reset();
    cycle(1, 32'hABC0, 6'h05, 32'h1234, 0);
    cycle(0, '0, '0, '0, 0);
    chk("post_rst_count", 96'(count), 96'd1);
    drain();

    // Randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 0) do_reset();
      op = ($urandom_range(0, 39) == 0) ? HALT : 6'($urandom_range(0, 62));
      cycle($urandom_range(0, 3) != 0, pc, op, $urandom, $urandom_range(0, 2) == 0);
      pc = pc + 32'd4;
    end
    drain();
    chk("sb_empty", 96'(sb.size()), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
